// File: rtl/inst_uncache_axi.sv
// inst_uncache_axi: serves uncached instruction fetches with single-beat AXI4 reads.
// Optional `INST_UC_BUSERR_EN adds buserr_o, which reports SLVERR/DECERR on the returned word.
module inst_uncache_axi #(
    parameter logic [3:0]  AXI_ID     = 4'h0,
    parameter logic [31:0] RESET_INST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        axi_stall_o,
`ifdef INST_UC_BUSERR_EN
    output logic        buserr_o,
`endif
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    typedef enum logic [2:0] {IDLE, AR, R, DONE, DRAIN} state_t;
    state_t state;
    logic cancel, accept, misalign, last_beat, kill, unused_bits;
    assign accept      = state == IDLE && req_i && !flush_i && addr_i[1:0] == 2'b00;
    assign misalign    = state == IDLE && req_i && !flush_i && addr_i[1:0] != 2'b00;
    assign last_beat   = rvalid && rready && rlast;
    assign kill        = cancel || flush_i;
    assign arid        = AXI_ID;
    assign arlen       = 8'd0;
    assign arsize      = 3'b010;
    assign arburst     = 2'b01;
    assign valid_o     = state == DONE && !flush_i;
    assign axi_stall_o = accept || state == AR || state == R || state == DRAIN;
    assign unused_bits = ^{addr_i[31:29], rresp};
`ifdef INST_UC_BUSERR_EN
    logic buserr;
    assign buserr_o = valid_o && buserr;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            cancel  <= 1'b0;
            inst_o  <= RESET_INST;
            araddr  <= 32'h0;
`ifdef INST_UC_BUSERR_EN
            buserr  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cancel <= 1'b0;
                    if (accept) begin
                        state   <= AR;
                        arvalid <= 1'b1;
                        araddr  <= {3'b000, addr_i[28:0]};
                    end else if (misalign) begin
                        state  <= DONE;
                        inst_o <= 32'h0;
`ifdef INST_UC_BUSERR_EN
                        buserr <= 1'b0;
`endif
                    end
                end
                AR: begin
                    cancel <= kill;
                    if (arready) begin
                        state   <= kill ? DRAIN : R;
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                R: begin
                    cancel <= kill;
                    // a flush arriving with the last beat already discards it
                    if (last_beat) begin
                        rready <= 1'b0;
                        state  <= kill ? IDLE : DONE;
`ifdef INST_UC_BUSERR_EN
                        if (!kill) inst_o <= rresp[1] ? 32'h0 : rdata;
                        if (!kill) buserr <= rresp[1];
`else
                        if (!kill) inst_o <= rdata;
`endif
                    end
                end
                DRAIN: begin
                    if (last_beat) begin
                        rready <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_uncache_axi.sv
// tb_inst_uncache_axi: randomized fetches against an AXI slave model with a scoreboard of expected words.
module tb_inst_uncache_axi;
    logic        clk = 1'b0;
    logic        rst, req_i, flush_i, valid_o, axi_stall_o, arvalid, arready, rlast, rvalid, rready;
    logic [31:0] addr_i, inst_o, araddr, rdata;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
`ifdef INST_UC_BUSERR_EN
    logic        buserr_o;
    localparam bit BE_EN = 1'b1;
`else
    localparam bit BE_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    inst_uncache_axi dut (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .flush_i(flush_i),
        .inst_o(inst_o), .valid_o(valid_o), .axi_stall_o(axi_stall_o),
`ifdef INST_UC_BUSERR_EN
        .buserr_o(buserr_o),
`endif
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    typedef struct {logic [31:0] inst; logic be; int vc;} exp_t;
    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] ar_q[$];
    int          n_chk = 0, n_pass = 0, cyc = 0;
    int          flush_cyc = 1 << 30, ar_dly = 0, r_dly = 0, nb = 1, last_c = 0, last_vc = 0, issue_cyc = 0;
    logic [31:0] plan_data = 32'h0, inst_model = 32'h0, prev_addr = 32'h0;
    logic [1:0]  plan_resp = 2'b00;
    bit          slave_done = 1'b0, prev_wait = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // slave: after each beat with rlast, decide from the flush cycle whether the word is captured and delivered
    initial begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (arvalid && !rst) begin
                repeat (ar_dly) @(negedge clk);
                arready = 1'b1;
                @(negedge clk);
                arready = 1'b0;
                for (int b = 0; b < nb; b++) begin
                    repeat (r_dly) @(negedge clk);
                    rlast  = b == nb - 1;
                    rdata  = rlast ? plan_data : $urandom;
                    rresp  = rlast ? plan_resp : 2'b00;
                    rvalid = 1'b1;
                    for (int w = 0; !rready && w < 50; w++) @(negedge clk);
                    if (rlast) begin
                        exp_t t;
                        t.be   = BE_EN && plan_resp[1];
                        t.inst = t.be ? 32'h0 : plan_data;
                        t.vc   = cyc + 1;
                        last_c = cyc;
                        if (flush_cyc > cyc) inst_model = t.inst;
                        if (flush_cyc > cyc + 1) exp_q.push_back(t);
                        slave_done = 1'b1;
                    end
                    @(negedge clk);
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (valid_o) begin
                if (exp_q.size() == 0) chk("unexpected valid_o", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("inst_o", inst_o, e.inst);
                    chk("valid cycle", cyc, e.vc);
`ifdef INST_UC_BUSERR_EN
                    chk("buserr_o", {31'h0, buserr_o}, {31'h0, e.be});
`endif
                    last_vc = cyc;
                end
            end
            if (prev_wait) begin
                chk("arvalid held", {31'h0, arvalid}, 32'd1);
                chk("araddr held", araddr, prev_addr);
            end
            if (arvalid || rready) chk("stall while busy", {31'h0, axi_stall_o}, 32'd1);
            if (arvalid && arready) begin
                if (ar_q.size() == 0) chk("unexpected AR", 32'd1, 32'd0);
                else begin
                    chk("araddr", araddr, ar_q.pop_front());
                    chk("ar fixed fields", {15'h0, arid, arlen, arsize, arburst}, {15'h0, 4'h0, 8'h0, 3'b010, 2'b01});
                end
            end else if (arvalid && ar_q.size() == 0) chk("unexpected arvalid", 32'd1, 32'd0);
            prev_wait = arvalid && !arready;
            prev_addr = araddr;
        end
    end

    // fa: flush cycle relative to the request cycle (>=1000 means no flush)
    task automatic fetch(input logic [31:0] addr, input int fa, input int ad, input int rd, input int b,
                         input logic [31:0] d, input logic [1:0] rs);
        int  k;
        bit  al, done;
        exp_t t;
        al = addr[1:0] == 2'b00;
        ar_dly = ad; r_dly = rd; nb = b; plan_data = d; plan_resp = rs; slave_done = 1'b0;
        @(negedge clk);
        issue_cyc = cyc;
        flush_cyc = cyc + fa;
        req_i = 1'b1; addr_i = addr; flush_i = fa == 0;
        if (fa != 0) begin
            if (al) ar_q.push_back({3'b000, addr[28:0]});
            else begin
                inst_model = 32'h0;
                t.inst = 32'h0; t.be = 1'b0; t.vc = cyc + 1;
                if (fa > 1) exp_q.push_back(t);
            end
        end
        #1 chk("stall at request", {31'h0, axi_stall_o}, {31'h0, al && fa != 0});
        k = 0;
        done = 1'b0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
            req_i = 1'b0;
            flush_i = k == fa;
            done = ((al && fa != 0) ? (slave_done && cyc >= last_c + 2) : k >= 2) && (fa >= 1000 || k > fa);
        end
        if (!done) begin
            $display("FAIL fetch timeout: got %0d cycles expected under 300", k);
            $fatal(1);
        end
        #1 chk("inst_o after fetch", inst_o, inst_model);
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; addr_i = 32'h0; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset inst_o", inst_o, 32'h0);
        chk("reset valid_o", {31'h0, valid_o}, 32'd0);
        chk("reset arvalid", {31'h0, arvalid}, 32'd0);
        chk("reset rready", {31'h0, rready}, 32'd0);
        chk("reset stall", {31'h0, axi_stall_o}, 32'd0);
        chk("reset araddr", araddr, 32'h0);
        rst = 1'b0;
        fetch(32'hBFC00000, 1000, 0, 0, 1, 32'h3C1D0000, 2'b00);
        chk("beat cycle", last_c, issue_cyc + 2);
        chk("valid latency", last_vc, issue_cyc + 3);
        fetch(32'hBFC00100, 1000, 5, 0, 1, 32'h24080001, 2'b00);
        fetch(32'hBFC00200, 2, 0, 3, 1, 32'hDEADBEEF, 2'b00);
        fetch(32'hBFC00204, 1000, 0, 1, 1, 32'h00000000 + 32'h11112222, 2'b00);
        fetch(32'hBFC00300, 0, 0, 0, 1, 32'hCAFEF00D, 2'b00);
        fetch(32'hBFC00002, 1000, 0, 0, 1, 32'h55555555, 2'b00);
        chk("misaligned valid latency", last_vc, issue_cyc + 1);
        fetch(32'hBFC00400, 1000, 0, 0, 1, 32'h12345678, 2'b10);
        fetch(32'hBFC00500, 1000, 2, 1, 3, 32'h0BADC0DE, 2'b00);
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int fa;
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            fa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : 1000;
            fetch(a, fa, $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(1, 3), $urandom, 2'($urandom));
        end
        repeat (3) @(negedge clk);
        chk("expected words left", exp_q.size(), 32'd0);
        chk("expected ARs left", ar_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
